vdc_htiming: RTL and testbench
==============================

# vdc_htiming

Parametrised horizontal timing generator for the VDC display pipeline. It generates the per-pixel and per-column horizontal state: column/pixel counters, `NWIN` independent display-enable windows, internally positioned hsync, and hblank. Register inputs pass through line-boundary shadow latches so CPU writes never tear a scanline. It drives the fetch/attribute stages and the vertical timing block, which consumes `line_end`.

## Interface
Parameters:
- `COLW`, 8: column counter and column-register width.
- `PIXW`, 4: pixel counter width.
- `NWIN`, 2: number of display-enable windows. Window 0 is the main display enable.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: pixel-clock enable. When low, all state holds.
- `db_in`, in, 8: CPU data bus, used as the pseudo-random source.
- `reg_ht`, in, COLW: horizontal total minus 1.
- `reg_hd`, in, COLW: horizontal displayed.
- `reg_hsp`, in, COLW: hsync start column.
- `reg_hw`, in, 4: sync/blank width plus 1.
- `reg_cth`, in, PIXW: character total horizontal minus 1.
- `reg_atr`, in, 1: attribute enable.
- `reg_dbl`, in, 1: pixel double width.
- `reg_ai`, in, 8: address increment per row.
- `win_beg`, in, NWIN*COLW: packed window begin columns.
- `win_end`, in, NWIN*COLW: packed window end columns.
- `newCol`, out, 1: pulses on the first pixel of a column.
- `endCol`, out, 1: pulses on the last pixel of a column.
- `col`, out, COLW: current column.
- `pixel`, out, PIXW: current pixel within the column.
- `win_en`, out, NWIN: window enables.
- `hVisible`, out, 1: visible-column flag AND `win_en[0]`.
- `hsync`, out, 1: horizontal sync.
- `hblank`, out, 1: horizontal blanking.
- `line_end`, out, 1: one-pixel pulse coinciding with the column wrap.

## Operation
- **Shadow latch.** All `reg_*`, `win_beg` and `win_end` are latched into shadows at reset, and on `enable && endCol && col==sh_ht`. All logic below uses the shadows.
- **Per enabled cycle:**
  - `newCol <= endCol`.
  - `endCol <= (pixel == sh_cth-1)`, computed in PIXW bits with wrap.
  - If `endCol`: `pixel <= {0, sh_dbl}`. Otherwise `pixel <= pixel+1`.
- **Column advance (on `endCol`).** If `col==sh_ht`: `col <= 0` and `line_end <= 1`. Otherwise `col <= col+1` and `line_end <= 0`.
- **Window adjust (per window k).** `adj(x) = (x>=7 && x<sh_hd+7) ? x+2 : x+1`, computed in COLW bits, modulo. Let `b = adj(beg_k)` and `e = adj(end_k)`.
- **Window state (on `endCol`, window k).**
  - If `b != e`: `col==b` sets the window and `col==e` clears it. If both match, clear wins.
  - At wrap, the window is set when `b >= sh_ht`.
  - If `b == e`: see Configuration.
- **Visible column.**
  - `hviscol` sets on `endCol` when `col==8`.
  - It clears when either condition holds:
    - `sh_dbl && newCol && col==sh_hd+9`
    - `!sh_dbl && endCol && col==sh_hd+((|sh_ai && !sh_atr) ? 7 : 8)`
  - The clear takes priority over the set.
- **Sync and blank (on `endCol`).**
  - `hsync <= (col==sh_hsp)`: a one-column pulse.
  - When `col==sh_hsp`, load the blank counter with `sh_hw >> sh_dbl`. Otherwise, if it is nonzero, decrement it.
  - `hblank = |counter`.
  - If `sh_hw>>sh_dbl == 0`, there is no blank.

## Timing
- **Reset values:**
  - `col=0`, `pixel={0,reg_dbl}`
  - `newCol=0`, `endCol=1`
  - `win_en=0`, `hviscol=0`
  - `hsync=0`, blank counter 0, `line_end=0`
- **First enabled cycle after reset.** `endCol=1` advances `col` to 1, so the first full column after reset is column 1.
- **Output latency.** Every output except `hblank` and `hVisible` is registered: it changes on the pixel after the `endCol` pixel, coincident with `newCol`. `hblank` and `hVisible` are combinational from registers.
- **Shadow latch timing.** Values latched at wrap are first used in column 0's compares.
- **Simultaneous events.**
  - Window set and wrap-set on the same edge: set.
  - `col==sh_hsp` while blank is counting: the counter reloads.
- **Reset mid-line.** State is restored immediately on the next edge, regardless of `enable`.

## Configuration
- `VDC_HRANDOM_EN` defined: when `b==e` and `col==b` on `endCol`, `win_en[k] <= db_in[0]^db_in[1]^db_in[5]^db_in[7]`. This emulates real-chip instability.
- Not defined: when `b==e`, the window is held at 0 (deterministic, for simulation and regression).

## Structure
- **Package `vdc_htiming_pkg`:**
  - Constants `VIS_START_COL=8` and `ADJ_THRESH=7`.
  - Function `win_adj(x, hd)`.
  - Typedef for the packed window-register arrays.
- **Sub-module `vdc_hwindow`:** one window's compare/set/clear/random logic, instantiated NWIN times via generate.

## Test plan
- **Defaults.** Set `ht=126, hd=80, cth=7, dbl=0, hw=9, hsp=102, win0 beg=125/end=100`, then run 2 lines.
  - Line period: 127×8 pixels, with `line_end` once per line.
  - `win_en[0]` rises at column 0 and falls after column 101.
  - `hsync` is high for column 103 only.
  - `hblank` lasts 9 columns.
- **Double width.** Repeat with `dbl=1, cth=7`.
  - Columns are 7 pixels.
  - Blank lasts 4 columns.
  - `hviscol` falls on `newCol` at column 89.
- **Shadowing.** Write `ht=60` mid-line at column 30.
  - The current line still wraps at 126.
  - The next line wraps at 60.
- **Random window.** Set `beg=end=20`.
  - With the macro and `db_in=8'h01`: `win_en[0]=1`.
  - With the macro and `db_in=8'h03`: 0.
  - Without the macro: always 0.
- **Enable and reset.** Hold `enable=0` for 50 cycles: all outputs are frozen. Assert `reset` at column 40: the next cycle shows `col=0, endCol=1, win_en=0`.

Source files
------------

// File: rtl/vdc_htiming_pkg.sv
// Shared constants, types and the window-column adjust helper for the
// VDC horizontal timing generator.
package vdc_htiming_pkg;

    localparam int unsigned VIS_START_COL = 8;
    localparam int unsigned ADJ_THRESH    = 7;

    // Widest column register the helpers below are sized for.
    localparam int unsigned COLW_MAX = 16;
    localparam int unsigned NWIN_MAX = 8;

    typedef logic [COLW_MAX-1:0] col_word_t;
    typedef col_word_t [NWIN_MAX-1:0] win_regs_t;

    // Columns inside the displayed span sit one pixel-pipeline stage later
    // than those outside it; all arithmetic wraps at colw bits.
    function automatic col_word_t win_adj(input col_word_t   x,
                                          input col_word_t   hd,
                                          input int unsigned colw);
        col_word_t mask;
        col_word_t lim;
        mask = col_word_t'((32'd1 << colw) - 32'd1);
        lim  = (hd + col_word_t'(ADJ_THRESH)) & mask;
        if ((x >= col_word_t'(ADJ_THRESH)) && (x < lim))
            win_adj = (x + col_word_t'(2)) & mask;
        else
            win_adj = (x + col_word_t'(1)) & mask;
    endfunction

endpackage

// File: rtl/vdc_hwindow.sv
// One display-enable window: adjusted begin/end compare with set/clear.
// VDC_HRANDOM_EN selects pseudo-random behaviour when begin == end.
module vdc_hwindow
    import vdc_htiming_pkg::*;
#(
    parameter int unsigned COLW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            end_col,
    input  logic            col_wrap,
    input  logic [COLW-1:0] col,
    input  logic [COLW-1:0] sh_ht,
    input  logic [COLW-1:0] sh_hd,
    input  logic [COLW-1:0] beg_col,
    input  logic [COLW-1:0] fin_col,
    input  logic            rnd_bit,
    output logic            win_en
);

    logic [COLW-1:0] beg_adj;
    logic [COLW-1:0] fin_adj;
    logic            degen;

    assign beg_adj = COLW'(win_adj(col_word_t'(beg_col), col_word_t'(sh_hd), COLW));
    assign fin_adj = COLW'(win_adj(col_word_t'(fin_col), col_word_t'(sh_hd), COLW));
    assign degen   = (beg_adj == fin_adj);

    // Clear beats set; the wrap-set reopens windows that begin past the total.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_en <= 1'b0;
        end else if (enable && end_col) begin
            if (degen) begin
`ifdef VDC_HRANDOM_EN
                if (col == beg_adj)
                    win_en <= rnd_bit;
`else
                win_en <= 1'b0;
`endif
            end else if (col == fin_adj) begin
                win_en <= 1'b0;
            end else if ((col == beg_adj) || (col_wrap && (beg_adj >= sh_ht))) begin
                win_en <= 1'b1;
            end
        end
    end

`ifndef VDC_HRANDOM_EN
    logic unused_rnd;
    assign unused_rnd = rnd_bit;
`endif

endmodule

// File: rtl/vdc_htiming.sv
// VDC horizontal timing: pixel/column counters, display windows, hsync/hblank.
// Define VDC_HRANDOM_EN for chip-like random windows when begin == end.
module vdc_htiming
    import vdc_htiming_pkg::*;
#(
    parameter int unsigned COLW = 8,
    parameter int unsigned PIXW = 4,
    parameter int unsigned NWIN = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           db_in,
    input  logic [COLW-1:0]      reg_ht,
    input  logic [COLW-1:0]      reg_hd,
    input  logic [COLW-1:0]      reg_hsp,
    input  logic [3:0]           reg_hw,
    input  logic [PIXW-1:0]      reg_cth,
    input  logic                 reg_atr,
    input  logic                 reg_dbl,
    input  logic [7:0]           reg_ai,
    input  logic [NWIN*COLW-1:0] win_beg,
    input  logic [NWIN*COLW-1:0] win_end,
    output logic                 newCol,
    output logic                 endCol,
    output logic [COLW-1:0]      col,
    output logic [PIXW-1:0]      pixel,
    output logic [NWIN-1:0]      win_en,
    output logic                 hVisible,
    output logic                 hsync,
    output logic                 hblank,
    output logic                 line_end
);

    logic [COLW-1:0]            sh_ht;
    logic [COLW-1:0]            sh_hd;
    logic [COLW-1:0]            sh_hsp;
    logic [3:0]                 sh_hw;
    logic [PIXW-1:0]            sh_cth;
    logic                       sh_atr;
    logic                       sh_dbl;
    logic [7:0]                 sh_ai;
    logic [NWIN-1:0][COLW-1:0]  sh_beg;
    logic [NWIN-1:0][COLW-1:0]  sh_end;

    logic                       hviscol;
    logic [3:0]                 blank_cnt;

    logic                       col_wrap_c;
    logic [PIXW-1:0]            cth_last_c;
    logic [COLW-1:0]            vis_end_col_c;
    logic [COLW-1:0]            vis_end_dbl_c;
    logic                       vis_clr_c;
    logic                       vis_set_c;
    logic [3:0]                 blank_load_c;
    logic                       rnd_bit_c;

    assign col_wrap_c    = endCol && (col == sh_ht);
    assign cth_last_c    = sh_cth - PIXW'(1);
    assign vis_end_col_c = sh_hd + (((|sh_ai) && !sh_atr) ? COLW'(VIS_START_COL - 1)
                                                          : COLW'(VIS_START_COL));
    assign vis_end_dbl_c = sh_hd + COLW'(VIS_START_COL + 1);
    assign vis_clr_c     = (sh_dbl && newCol && (col == vis_end_dbl_c)) ||
                           (!sh_dbl && endCol && (col == vis_end_col_c));
    assign vis_set_c     = endCol && (col == COLW'(VIS_START_COL));
    assign blank_load_c  = sh_hw >> sh_dbl;
    assign rnd_bit_c     = db_in[0] ^ db_in[1] ^ db_in[5] ^ db_in[7];

    logic unused_db;
    assign unused_db = ^{db_in[6], db_in[4:2]};

    // Shadows only move at the line wrap so a scanline never sees a torn setup.
    always_ff @(posedge clk) begin
        if (reset || (enable && col_wrap_c)) begin
            sh_ht  <= reg_ht;
            sh_hd  <= reg_hd;
            sh_hsp <= reg_hsp;
            sh_hw  <= reg_hw;
            sh_cth <= reg_cth;
            sh_atr <= reg_atr;
            sh_dbl <= reg_dbl;
            sh_ai  <= reg_ai;
            sh_beg <= win_beg;
            sh_end <= win_end;
        end
    end

    // Pixel and column counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            col      <= '0;
            pixel    <= PIXW'(reg_dbl);
            newCol   <= 1'b0;
            endCol   <= 1'b1;
            line_end <= 1'b0;
        end else if (enable) begin
            newCol   <= endCol;
            endCol   <= (pixel == cth_last_c);
            line_end <= col_wrap_c;
            if (endCol) begin
                pixel <= PIXW'(sh_dbl);
                col   <= col_wrap_c ? '0 : col + COLW'(1);
            end else begin
                pixel <= pixel + PIXW'(1);
            end
        end
    end

    // Visible-column flag; clear has priority over set.
    always_ff @(posedge clk) begin
        if (reset) begin
            hviscol <= 1'b0;
        end else if (enable) begin
            if (vis_clr_c)
                hviscol <= 1'b0;
            else if (vis_set_c)
                hviscol <= 1'b1;
        end
    end

    // Sync pulse and blank countdown, both stepped once per column.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync     <= 1'b0;
            blank_cnt <= '0;
        end else if (enable && endCol) begin
            hsync <= (col == sh_hsp);
            if (col == sh_hsp)
                blank_cnt <= blank_load_c;
            else if (|blank_cnt)
                blank_cnt <= blank_cnt - 4'd1;
        end
    end

    for (genvar k = 0; k < int'(NWIN); k++) begin : g_win
        vdc_hwindow #(
            .COLW (COLW)
        ) u_win (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .end_col  (endCol),
            .col_wrap (col_wrap_c),
            .col      (col),
            .sh_ht    (sh_ht),
            .sh_hd    (sh_hd),
            .beg_col  (sh_beg[k]),
            .fin_col  (sh_end[k]),
            .rnd_bit  (rnd_bit_c),
            .win_en   (win_en[k])
        );
    end

    assign hblank   = |blank_cnt;
    assign hVisible = hviscol && win_en[0];

endmodule

// File: tb/tb_vdc_htiming.sv
// Self-checking bench for vdc_htiming: rule-level reference model plus
// directed line measurements and randomized register/enable traffic.
module tb_vdc_htiming;

    localparam int COLW = 8;
    localparam int PIXW = 4;
    localparam int NWIN = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [7:0]           db_in;
    logic [COLW-1:0]      reg_ht, reg_hd, reg_hsp;
    logic [3:0]           reg_hw;
    logic [PIXW-1:0]      reg_cth;
    logic                 reg_atr, reg_dbl;
    logic [7:0]           reg_ai;
    logic [NWIN*COLW-1:0] win_beg, win_end;
    logic                 newCol, endCol, hVisible, hsync, hblank, line_end;
    logic [COLW-1:0]      col;
    logic [PIXW-1:0]      pixel;
    logic [NWIN-1:0]      win_en;

    always #5 clk = ~clk;

    vdc_htiming #(.COLW(COLW), .PIXW(PIXW), .NWIN(NWIN)) dut (
        .clk(clk), .reset(reset), .enable(enable), .db_in(db_in),
        .reg_ht(reg_ht), .reg_hd(reg_hd), .reg_hsp(reg_hsp), .reg_hw(reg_hw),
        .reg_cth(reg_cth), .reg_atr(reg_atr), .reg_dbl(reg_dbl), .reg_ai(reg_ai),
        .win_beg(win_beg), .win_end(win_end),
        .newCol(newCol), .endCol(endCol), .col(col), .pixel(pixel),
        .win_en(win_en), .hVisible(hVisible), .hsync(hsync), .hblank(hblank),
        .line_end(line_end)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, kept as plain integers.
    int m_col, m_pix, m_nc, m_ec, m_le, m_vis, m_hs, m_cnt;
    int m_win [NWIN];
    int s_ht, s_hd, s_hsp, s_hw, s_cth, s_atr, s_dbl, s_ai;
    int s_beg [NWIN];
    int s_end [NWIN];

    function automatic int adj(input int x, input int hd);
        int lim;
        lim = (hd + 7) % 256;
        if (x >= 7 && x < lim) return (x + 2) % 256;
        return (x + 1) % 256;
    endfunction

    task automatic latch_shadows();
        s_ht = int'(reg_ht); s_hd = int'(reg_hd); s_hsp = int'(reg_hsp);
        s_hw = int'(reg_hw); s_cth = int'(reg_cth); s_atr = int'(reg_atr);
        s_dbl = int'(reg_dbl); s_ai = int'(reg_ai);
        for (int k = 0; k < NWIN; k++) begin
            s_beg[k] = int'(win_beg[k*COLW +: COLW]);
            s_end[k] = int'(win_end[k*COLW +: COLW]);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int wrap, n_col, n_pix, n_ec, b, e, clr, stop;
        if (reset) begin
            latch_shadows();
            m_col = 0; m_pix = int'(reg_dbl); m_nc = 0; m_ec = 1; m_le = 0;
            m_vis = 0; m_hs = 0; m_cnt = 0;
            for (int k = 0; k < NWIN; k++) m_win[k] = 0;
        end else if (enable) begin
            wrap  = (m_ec != 0 && m_col == s_ht) ? 1 : 0;
            n_ec  = (m_pix == (s_cth + 15) % 16) ? 1 : 0;
            n_pix = (m_ec != 0) ? s_dbl : (m_pix + 1) % 16;
            n_col = (m_ec == 0) ? m_col : (wrap != 0 ? 0 : (m_col + 1) % 256);
            if (m_ec != 0) begin
                for (int k = 0; k < NWIN; k++) begin
                    b = adj(s_beg[k], s_hd);
                    e = adj(s_end[k], s_hd);
                    if (b == e) begin
`ifdef VDC_HRANDOM_EN
                        if (m_col == b) m_win[k] = int'(db_in[0] ^ db_in[1] ^ db_in[5] ^ db_in[7]);
`else
                        m_win[k] = 0;
`endif
                    end else if (m_col == e) m_win[k] = 0;
                    else if (m_col == b || (wrap != 0 && b >= s_ht)) m_win[k] = 1;
                end
            end
            stop = (s_ai != 0 && s_atr == 0) ? 7 : 8;
            clr = ((s_dbl != 0 && m_nc != 0 && m_col == (s_hd + 9) % 256) ||
                   (s_dbl == 0 && m_ec != 0 && m_col == (s_hd + stop) % 256)) ? 1 : 0;
            if (clr != 0) m_vis = 0;
            else if (m_ec != 0 && m_col == 8) m_vis = 1;
            if (m_ec != 0) begin
                m_hs = (m_col == s_hsp) ? 1 : 0;
                if (m_col == s_hsp) m_cnt = s_hw >> s_dbl;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
            m_le = wrap; m_nc = m_ec; m_ec = n_ec; m_pix = n_pix; m_col = n_col;
            if (wrap != 0) latch_shadows();
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [NWIN-1:0] w;
        for (int k = 0; k < NWIN; k++) w[k] = (m_win[k] != 0);
        return 64'({COLW'(m_col), PIXW'(m_pix), m_nc != 0, m_ec != 0, m_le != 0, w,
                    (m_vis != 0 && m_win[0] != 0), m_hs != 0, m_cnt != 0});
    endfunction

    function automatic logic [63:0] dut_vec();
        return 64'({col, pixel, newCol, endCol, line_end, win_en, hVisible, hsync, hblank});
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("state", dut_vec(), model_vec());
    endtask

    // Per-line measurements filled by run_line.
    int ln_cycles, ln_maxcol, ln_hs_col, ln_hs_cols, ln_blank_cols;
    int ln_win_first, ln_win_last, ln_win_cols, ln_vis_fall, ln_le_cnt;

    // Run until the next line_end pulse, measuring the samples along the way.
    task automatic run_line();
        int prev_hv;
        bit seen;
        seen = 1'b0;
        ln_cycles = 0; ln_maxcol = 0; ln_hs_col = -1; ln_hs_cols = 0; ln_blank_cols = 0;
        ln_win_first = -1; ln_win_last = -1; ln_win_cols = 0; ln_vis_fall = -1; ln_le_cnt = 0;
        prev_hv = int'(hVisible);
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (int'(col) > ln_maxcol) ln_maxcol = int'(col);
            if (line_end) ln_le_cnt++;
            if (newCol) begin
                if (hsync) begin ln_hs_cols++; ln_hs_col = int'(col); end
                if (hblank) ln_blank_cols++;
                if (win_en[0]) begin
                    ln_win_cols++;
                    if (ln_win_first < 0) ln_win_first = int'(col);
                    ln_win_last = int'(col);
                end
            end
            if (prev_hv == 1 && !hVisible && ln_vis_fall < 0) ln_vis_fall = int'(col);
            prev_hv = int'(hVisible);
            tick();
            ln_cycles++;
            if (line_end) seen = 1'b1;
        end
        check("line_end_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_col(input int target);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            tick();
            if (int'(col) == target && newCol) seen = 1'b1;
        end
        check("col_reached", 64'(seen), 64'd1);
    endtask

    task automatic set_defaults();
        reg_ht = 8'd126; reg_hd = 8'd80; reg_hsp = 8'd102; reg_hw = 4'd9;
        reg_cth = 4'd7; reg_atr = 1'b0; reg_dbl = 1'b0; reg_ai = 8'd0;
        win_beg = {8'd10, 8'd125};
        win_end = {8'd50, 8'd100};
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] frozen;
        int exp_rnd;
        reset = 1'b1; enable = 1'b1; db_in = 8'h00;
        set_defaults();
        tick();
        check("rst_col", 64'(col), 64'd0);
        check("rst_endcol", 64'(endCol), 64'd1);
        check("rst_pixel", 64'(pixel), 64'd0);
        reset = 1'b0;

        // Default geometry: 127 columns of 8 pixels.
        run_line();
        run_line();
        check("def_period", 64'(ln_cycles), 64'(127 * 8));
        check("def_line_end_cnt", 64'(ln_le_cnt), 64'd1);
        check("def_hsync_col", 64'(ln_hs_col), 64'd103);
        check("def_hsync_len", 64'(ln_hs_cols), 64'd1);
        check("def_blank_cols", 64'(ln_blank_cols), 64'd9);
        check("def_win_first", 64'(ln_win_first), 64'd0);
        check("def_win_last", 64'(ln_win_last), 64'd101);
        check("def_vis_fall", 64'(ln_vis_fall), 64'd89);

        // Double width: 7-pixel columns and halved blank.
        reg_dbl = 1'b1;
        run_line();
        run_line();
        run_line();
        check("dbl_period", 64'(ln_cycles), 64'(127 * 7));
        check("dbl_blank_cols", 64'(ln_blank_cols), 64'd4);
        check("dbl_vis_fall", 64'(ln_vis_fall), 64'd89);
        check("dbl_hsync_col", 64'(ln_hs_col), 64'd103);

        // Shadowing: a mid-line total write only takes effect next line.
        reg_dbl = 1'b0;
        apply_reset();
        run_line();
        wait_col(30);
        reg_ht = 8'd60;
        run_line();
        check("shd_cur_maxcol", 64'(ln_maxcol), 64'd126);
        run_line();
        check("shd_next_maxcol", 64'(ln_maxcol), 64'd60);
        check("shd_next_period", 64'(ln_cycles), 64'(61 * 8));

        // Degenerate window begin == end.
        set_defaults();
        win_beg[7:0] = 8'd20;
        win_end[7:0] = 8'd20;
        db_in = 8'h01;
        apply_reset();
        run_line();
        run_line();
`ifdef VDC_HRANDOM_EN
        exp_rnd = 127;
`else
        exp_rnd = 0;
`endif
        check("rnd_db01", 64'(ln_win_cols), 64'(exp_rnd));
        db_in = 8'h03;
        run_line();
        run_line();
        check("rnd_db03", 64'(ln_win_cols), 64'd0);

        // Enable hold, then synchronous reset mid-line with enable low.
        set_defaults();
        db_in = 8'h00;
        apply_reset();
        wait_col(20);
        frozen = model_vec();
        enable = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        check("frozen", dut_vec(), frozen);
        enable = 1'b1;
        wait_col(40);
        check("pre_rst_win1", 64'(win_en[1]), 64'd1);
        reset = 1'b1;
        enable = 1'b0;
        tick();
        check("mid_rst_col", 64'(col), 64'd0);
        check("mid_rst_endcol", 64'(endCol), 64'd1);
        check("mid_rst_win", 64'(win_en), 64'd0);
        reset = 1'b0;
        enable = 1'b1;

        // Randomized registers, enable gaps, bus noise and occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            reg_ht  = COLW'($urandom_range(20, 150));
            reg_hd  = COLW'($urandom_range(0, int'(reg_ht)));
            reg_hsp = COLW'($urandom_range(0, int'(reg_ht)));
            reg_hw  = 4'($urandom);
            reg_cth = PIXW'($urandom);
            reg_dbl = 1'($urandom);
            reg_atr = 1'($urandom);
            reg_ai  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            for (int k = 0; k < NWIN; k++) begin
                win_beg[k*COLW +: COLW] = COLW'($urandom_range(0, int'(reg_ht) + 2));
                win_end[k*COLW +: COLW] = COLW'($urandom_range(0, int'(reg_ht) + 2));
                if ($urandom_range(0, 7) == 0) win_end[k*COLW +: COLW] = win_beg[k*COLW +: COLW];
            end
            for (int i = 0; i < 400; i++) begin
                enable = ($urandom_range(0, 9) != 0);
                db_in  = 8'($urandom);
                reset  = ($urandom_range(0, 1999) == 0);
                tick();
            end
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
